monobit_freq_test: RTL and testbench
====================================

# monobit_freq_test

Streaming NIST-style monobit (frequency) test engine, the parametrised successor to the 4-bit combinational adder in the `tt_um_monobit` tile. It accumulates ones over a block of 2^N_LOG2 serial bits and forms |S| = |2·ones − N|. It compares |S| against a threshold latched at block start and reports pass/fail with a one-cycle done strobe. Running block and fail counters are included. It sits behind the tile's `ui_in` bit source and drives result fields onto `uo_out`/`uio_out`.

## Interface
- `N_LOG2`, default 7: block length N = 2^N_LOG2 bits; legal range 2..15.
- `CNT_W`, default N_LOG2+1 (derived, not overridable): width of the ones count and |S|.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset; the only way to clear the statistics counters.
- `ena`  in  1  global enable; when low, all state and counters hold and `done` is 0.
- `start`  in  1  begin a new block; clears count, latches `thresh`, aborts any block in progress.
- `bit_valid`  in  1  `bit_in` is valid this cycle.
- `bit_in`  in  1  test bit.
- `thresh`  in  CNT_W  maximum |S| that passes; sampled only on an accepted `start`.
- `busy`  out  1  high in COLLECT or EVAL.
- `done`  out  1  one-cycle pulse when a result is published.
- `pass`  out  1  result of the last completed block; held until the next result.
- `ones`  out  CNT_W  ones count of the last completed block; held.
- `s_abs`  out  CNT_W  |2·ones − N| of the last completed block; held.
- `block_cnt`  out  16  completed blocks; saturates at 0xFFFF.
- `fail_cnt`  out  16  failed blocks; saturates at 0xFFFF.

## Operation
- States: IDLE → COLLECT → EVAL → IDLE. The state is held whenever `ena` = 0.
- IDLE: `start` moves the FSM to COLLECT, clears the bit counter and accumulator, and latches `thresh`. Bits arriving while in IDLE are ignored.
- COLLECT:
  - Each cycle with `ena` & `bit_valid` accepts one bit, increments the bit counter, and adds `bit_in` to the accumulator.
  - After the Nth bit is accepted, the FSM moves to EVAL.
- EVAL (exactly one cycle):
  - Computes S = 2·acc − N in CNT_W+1 bits signed, then |S| in CNT_W bits. The maximum |S| is N, so it fits.
  - Registers `ones`, `s_abs`, and `pass` = (|S| ≤ latched thresh).
  - Pulses `done`, increments `block_cnt`, and increments `fail_cnt` if the block failed.
  - Returns to IDLE.
- `start` has priority in every state. Asserting it in COLLECT or EVAL restarts the block. The aborted block produces no `done` and no counter or result update.
- `start` and `bit_valid` in the same cycle: `start` wins and the bit is discarded.
- Result outputs change only in EVAL. Everything else holds them.

## Timing
- Reset values: state IDLE; `busy`, `done`, and `pass` are 0; `ones`, `s_abs`, `block_cnt`, `fail_cnt`, and the latched threshold are 0.
- `busy` is registered. It rises on the edge that accepts `start` and falls on the edge that leaves EVAL.
- Latency: the final bit is accepted at edge e. `done`, `pass`, `ones`, and `s_abs` update at edge e+1. `done` is high for exactly the cycle after e+1.
- Minimum block period is N+2 cycles: one cycle for `start`, N bits, one cycle in EVAL.
- `ena` low during EVAL stretches EVAL. `done` fires on the first enabled cycle.
- Asynchronous reset mid-block returns every register to its reset value immediately. No `done` is produced.

## Structure
- Package `monobit_pkg` holds the state enum (`IDLE`, `COLLECT`, `EVAL`) and the 16-bit statistics-counter width constant.
- One sub-module, `monobit_eval`: purely combinational `acc`, `thresh` → `s_abs`, `pass`, parametrised by N_LOG2. The FSM, counters, and registers stay in the top module.
- A tile wrapper (outside this block) maps `ui_in`/`uo_out`.

## Test plan
All scenarios use N_LOG2 = 3 (N = 8).
- Alternating 1010_1010, thresh = 0 → `ones` = 4, `s_abs` = 0, `pass` = 1, `done` exactly 1 cycle, `block_cnt` = 1.
- All ones, thresh = 2 → `ones` = 8, `s_abs` = 8, `pass` = 0, `fail_cnt` = 1. Then all zeros → `s_abs` = 8, `fail_cnt` = 2.
- 5 ones / 3 zeros, thresh = 2 → `s_abs` = 2, `pass` = 1 (equality boundary). Repeat with thresh = 1 → `pass` = 0.
- `start` after 4 bits, then 8 fresh bits → only one `done`, `block_cnt` increments by 1, result reflects the fresh bits only. Also drive `start` with `bit_valid` in the same cycle → that bit is discarded.
- Random `bit_valid` gaps and `ena` low during COLLECT and EVAL → same result as a gapless run, and `done` is never asserted while `ena` = 0.
- `rst_n` low mid-COLLECT → all outputs 0 asynchronously. A following full block reports a correct fresh result with `block_cnt` = 1.

Source files
------------

// File: rtl/monobit_pkg.sv
// Shared types and constants for the monobit frequency test engine.
package monobit_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        EVAL    = 2'd2
    } state_t;

    localparam int STAT_W = 16;

endpackage : monobit_pkg

// File: rtl/monobit_eval.sv
// Combinational block evaluation: |S| = |2*acc - N| and the threshold decision.
module monobit_eval #(
    parameter  int N_LOG2 = 7,
    localparam int CNT_W  = N_LOG2 + 1
) (
    input  logic [CNT_W-1:0] acc,
    input  logic [CNT_W-1:0] thresh,
    output logic [CNT_W-1:0] s_abs,
    output logic             pass
);

    logic [CNT_W:0] two_acc_s;
    logic [CNT_W:0] n_s;
    logic [CNT_W:0] s_s;
    logic [CNT_W:0] s_neg_s;

    // S is formed one bit wider than the count so that 2*acc and the sign both fit.
    always_comb begin
        two_acc_s = {acc, 1'b0};
        n_s       = (CNT_W + 1)'(1) << N_LOG2;
        s_s       = two_acc_s - n_s;
        s_neg_s   = (~s_s) + (CNT_W + 1)'(1);
        if (s_s[CNT_W]) begin
            s_abs = s_neg_s[CNT_W-1:0];
        end else begin
            s_abs = s_s[CNT_W-1:0];
        end
        pass = (s_abs <= thresh);
    end

endmodule : monobit_eval

// File: rtl/monobit_freq_test.sv
// Streaming monobit frequency test: collects 2^N_LOG2 bits, evaluates |S| against
// a latched threshold, and keeps saturating block/fail statistics.
module monobit_freq_test
    import monobit_pkg::*;
#(
    parameter  int N_LOG2 = 7,
    localparam int CNT_W  = N_LOG2 + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              start,
    input  logic              bit_valid,
    input  logic              bit_in,
    input  logic [CNT_W-1:0]  thresh,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  ones,
    output logic [CNT_W-1:0]  s_abs,
    output logic [STAT_W-1:0] block_cnt,
    output logic [STAT_W-1:0] fail_cnt
);

    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'((1 << N_LOG2) - 1);
    localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

    state_t             state_q,     state_d;
    logic [CNT_W-1:0]   bit_cnt_q,   bit_cnt_d;
    logic [CNT_W-1:0]   acc_q,       acc_d;
    logic [CNT_W-1:0]   thr_q,       thr_d;
    logic               busy_q,      busy_d;
    logic               done_q,      done_d;
    logic               pass_q,      pass_d;
    logic [CNT_W-1:0]   ones_q,      ones_d;
    logic [CNT_W-1:0]   s_abs_q,     s_abs_d;
    logic [STAT_W-1:0]  block_cnt_q, block_cnt_d;
    logic [STAT_W-1:0]  fail_cnt_q,  fail_cnt_d;

    logic [CNT_W-1:0]   eval_s_abs_s;
    logic               eval_pass_s;

    monobit_eval #(.N_LOG2(N_LOG2)) u_eval (
        .acc    (acc_q),
        .thresh (thr_q),
        .s_abs  (eval_s_abs_s),
        .pass   (eval_pass_s)
    );

    // Next-state logic; start always wins, and with ena low everything holds.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        acc_d       = acc_q;
        thr_d       = thr_q;
        done_d      = done_q;
        pass_d      = pass_q;
        ones_d      = ones_q;
        s_abs_d     = s_abs_q;
        block_cnt_d = block_cnt_q;
        fail_cnt_d  = fail_cnt_q;
        if (ena) begin
            done_d = 1'b0;
            if (start) begin
                state_d   = COLLECT;
                bit_cnt_d = CNT_W'(0);
                acc_d     = CNT_W'(0);
                thr_d     = thresh;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_d = IDLE;
                    end
                    COLLECT: begin
                        if (bit_valid) begin
                            acc_d     = acc_q + CNT_W'(bit_in);
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                            if (bit_cnt_q == LAST_BIT) begin
                                state_d = EVAL;
                            end else begin
                                state_d = COLLECT;
                            end
                        end else begin
                            state_d = COLLECT;
                        end
                    end
                    EVAL: begin
                        state_d = IDLE;
                        ones_d  = acc_q;
                        s_abs_d = eval_s_abs_s;
                        pass_d  = eval_pass_s;
                        done_d  = 1'b1;
                        if (block_cnt_q != STAT_MAX) begin
                            block_cnt_d = block_cnt_q + STAT_W'(1);
                        end else begin
                            block_cnt_d = block_cnt_q;
                        end
                        if (!eval_pass_s && (fail_cnt_q != STAT_MAX)) begin
                            fail_cnt_d = fail_cnt_q + STAT_W'(1);
                        end else begin
                            fail_cnt_d = fail_cnt_q;
                        end
                    end
                    default: begin
                        state_d = IDLE;
                    end
                endcase
            end
        end else begin
            state_d = state_q;
        end
        busy_d = (state_d != IDLE);
    end

    // State and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bit_cnt_q   <= CNT_W'(0);
            acc_q       <= CNT_W'(0);
            thr_q       <= CNT_W'(0);
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            ones_q      <= CNT_W'(0);
            s_abs_q     <= CNT_W'(0);
            block_cnt_q <= STAT_W'(0);
            fail_cnt_q  <= STAT_W'(0);
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            acc_q       <= acc_d;
            thr_q       <= thr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            ones_q      <= ones_d;
            s_abs_q     <= s_abs_d;
            block_cnt_q <= block_cnt_d;
            fail_cnt_q  <= fail_cnt_d;
        end
    end

    // A pending done that meets a disabled cycle is held and shown on the next enabled one.
    assign done      = done_q & ena;
    assign busy      = busy_q;
    assign pass      = pass_q;
    assign ones      = ones_q;
    assign s_abs     = s_abs_q;
    assign block_cnt = block_cnt_q;
    assign fail_cnt  = fail_cnt_q;

endmodule : monobit_freq_test

// File: tb/tb_monobit_freq_test.sv
// Self-checking bench for monobit_freq_test with N = 8: directed vector table,
// abort/reset sequences, and randomized gapped blocks against a popcount model.
module tb_monobit_freq_test;

    localparam int NL = 3;
    localparam int N  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ena;
    logic          start;
    logic          bit_valid;
    logic          bit_in;
    logic [CW-1:0] thresh;
    logic          busy;
    logic          done;
    logic          pass;
    logic [CW-1:0] ones;
    logic [CW-1:0] s_abs;
    logic [15:0]   block_cnt;
    logic [15:0]   fail_cnt;

    monobit_freq_test #(.N_LOG2(NL)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .start     (start),
        .bit_valid (bit_valid),
        .bit_in    (bit_in),
        .thresh    (thresh),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .ones      (ones),
        .s_abs     (s_abs),
        .block_cnt (block_cnt),
        .fail_cnt  (fail_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    int done_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // done must never be seen while ena is low
    always @(negedge clk) begin
        if (rst_n && done) begin
            done_seen++;
            check("done_only_when_enabled", 32'(ena), 32'd1);
        end
    end

    // Reference model computed straight from the definition of the test.
    function automatic int model_ones(input logic [7:0] b);
        int c = 0;
        for (int i = 0; i < N; i++) c += int'(b[i]);
        return c;
    endfunction

    function automatic int model_sabs(input logic [7:0] b);
        int s = 2 * model_ones(b) - N;
        return (s < 0) ? -s : s;
    endfunction

    function automatic int model_pass(input logic [7:0] b, input int thr);
        return (model_sabs(b) <= thr) ? 1 : 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [CW-1:0] thr, input logic with_bit);
        start     = 1'b1;
        thresh    = thr;
        ena       = 1'b1;
        bit_valid = with_bit;
        bit_in    = 1'b1;
        tick();
        start     = 1'b0;
        bit_valid = 1'b0;
        thresh    = CW'($urandom_range(15, 0));
    endtask

    task automatic drive_bits(input logic [7:0] b, input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                int g = $urandom_range(3, 0);
                for (int k = 0; k < g; k++) begin
                    ena       = $urandom_range(1, 0) == 1;
                    bit_valid = !ena && ($urandom_range(1, 0) == 1);
                    bit_in    = $urandom_range(1, 0) == 1;
                    tick();
                end
            end
            ena       = 1'b1;
            bit_valid = 1'b1;
            bit_in    = b[i];
            tick();
        end
        bit_valid = 1'b0;
    endtask

    // Waits (bounded) for done, then checks results and statistics.
    task automatic finish_block(input string tag, input int e_ones, input int e_sabs, input int e_pass,
                                input int bc0, input int fc0, input int ds0, input int stall,
                                input bit check_lat);
        int cyc = 0;
        if (stall > 0) begin
            ena = 1'b0;
            for (int k = 0; k < stall; k++) tick();
            check({tag, "_busy_stalled"}, 32'(busy), 32'd1);
            ena = 1'b1;
        end
        while (cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (done) break;
        end
        check({tag, "_done_seen"}, 32'(done), 32'd1);
        if (check_lat) check({tag, "_latency"}, cyc, 2);
        check({tag, "_ones"}, 32'(ones), e_ones);
        check({tag, "_s_abs"}, 32'(s_abs), e_sabs);
        check({tag, "_pass"}, 32'(pass), e_pass);
        check({tag, "_block_cnt"}, 32'(block_cnt), bc0 + 1);
        check({tag, "_fail_cnt"}, 32'(fail_cnt), fc0 + (e_pass == 0 ? 1 : 0));
        @(negedge clk);
        check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
        check({tag, "_busy_low"}, 32'(busy), 32'd0);
        check({tag, "_done_count"}, done_seen - ds0, 1);
    endtask

    typedef struct {
        logic [7:0]    bits;
        logic [CW-1:0] thr;
        int            e_ones;
        int            e_sabs;
        int            e_pass;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int bc0, fc0, ds0;
        rst_n = 1'b0; ena = 1'b0; start = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; thresh = '0;
        vecs[0] = '{8'b1010_1010, 4'd0, 4, 0, 1};
        vecs[1] = '{8'b1111_1111, 4'd2, 8, 8, 0};
        vecs[2] = '{8'b0000_0000, 4'd2, 0, 8, 0};
        vecs[3] = '{8'b1011_0101, 4'd2, 5, 2, 1};
        vecs[4] = '{8'b1011_0101, 4'd1, 5, 2, 0};

        #12;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_pass", 32'(pass), 32'd0);
        check("reset_block_cnt", 32'(block_cnt), 32'd0);
        rst_n = 1'b1;
        ena   = 1'b1;
        tick();

        // bits in IDLE are ignored
        bit_valid = 1'b1; bit_in = 1'b1;
        tick(); tick();
        bit_valid = 1'b0;
        check("idle_busy", 32'(busy), 32'd0);

        for (int v = 0; v < 5; v++) begin
            bc0 = block_cnt; fc0 = fail_cnt; ds0 = done_seen;
            do_start(vecs[v].thr, 1'b0);
            check($sformatf("vec%0d_busy_after_start", v), 32'(busy), 32'd1);
            drive_bits(vecs[v].bits, N, 1'b0);
            finish_block($sformatf("vec%0d", v), vecs[v].e_ones, vecs[v].e_sabs, vecs[v].e_pass,
                         bc0, fc0, ds0, 0, 1'b1);
        end

        // abort after 4 bits, restart with a bit in the start cycle that must be dropped
        bc0 = block_cnt; fc0 = fail_cnt; ds0 = done_seen;
        do_start(4'd3, 1'b0);
        drive_bits(8'hFF, 4, 1'b0);
        do_start(4'd3, 1'b1);
        drive_bits(8'b0000_0011, N, 1'b0);
        finish_block("abort", 2, 4, 0, bc0, fc0, ds0, 0, 1'b1);

        // randomized gapped blocks with ena stalls in COLLECT and EVAL
        for (int r = 0; r < 12; r++) begin
            logic [7:0]    rb;
            logic [CW-1:0] rt;
            rb = 8'($urandom);
            rt = CW'($urandom_range(8, 0));
            bc0 = block_cnt; fc0 = fail_cnt; ds0 = done_seen;
            do_start(rt, 1'($urandom_range(1, 0)));
            drive_bits(rb, N, 1'b1);
            finish_block($sformatf("rand%0d", r), model_ones(rb), model_sabs(rb), model_pass(rb, int'(rt)),
                         bc0, fc0, ds0, int'($urandom_range(3, 0)), 1'b0);
        end

        // asynchronous reset mid-COLLECT
        ds0 = done_seen;
        do_start(4'd8, 1'b0);
        drive_bits(8'hFF, 3, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_block_cnt", 32'(block_cnt), 32'd0);
        check("arst_fail_cnt", 32'(fail_cnt), 32'd0);
        check("arst_ones", 32'(ones), 32'd0);
        check("arst_s_abs", 32'(s_abs), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("arst_no_done", done_seen - ds0, 0);
        ds0 = done_seen;
        do_start(4'd4, 1'b0);
        drive_bits(8'b0111_0110, N, 1'b0);
        finish_block("post_rst", 5, 2, 1, 0, 0, ds0, 0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule : tb_monobit_freq_test
